// File: rtl/issue_queue_v2_pkg.sv
// Shared types for the issue queue: physical tag, opcode and the
// reservation-station entry layout.
package issue_queue_pkg;

    localparam int IQ_TAG_WIDTH  = 6;
    localparam int IQ_FUNC_WIDTH = 5;

    typedef logic [IQ_TAG_WIDTH-1:0]  tag_t;
    typedef logic [IQ_FUNC_WIDTH-1:0] func_t;

    typedef struct packed {
        logic  valid;
        func_t func;
        tag_t  src1_tag;
        logic  rdy1;
        tag_t  src2_tag;
        logic  rdy2;
        tag_t  dst_tag;
    } rs_entry_t;

    // Tag 0 names the always-ready register (immediates).
    localparam tag_t      ZERO_TAG    = '0;
    localparam rs_entry_t EMPTY_ENTRY = '0;

endpackage

// File: rtl/issue_queue_v2_if.sv
// Dispatch, wakeup and issue bundle between dispatcher/FU (master) and the
// issue queue (slave).
interface issue_queue_v2_if
    import issue_queue_pkg::*;
#(
    parameter int TAG_WIDTH   = IQ_TAG_WIDTH,
    parameter int FUNC_WIDTH  = IQ_FUNC_WIDTH,
    parameter int NUM_WAKEUP  = 2,
    parameter int ENTRY_WIDTH = 3
);
    logic                            dispatch_valid;
    logic                            dispatch_ready;
    logic [FUNC_WIDTH-1:0]           dispatch_func;
    logic [TAG_WIDTH-1:0]            dispatch_src1_tag;
    logic [TAG_WIDTH-1:0]            dispatch_src2_tag;
    logic                            dispatch_src1_ready;
    logic                            dispatch_src2_ready;
    logic [TAG_WIDTH-1:0]            dispatch_dst_tag;
    logic [NUM_WAKEUP-1:0]           wakeup_valid;
    logic [NUM_WAKEUP*TAG_WIDTH-1:0] wakeup_tag;
    logic                            issue_valid;
    logic                            issue_ready;
    logic [FUNC_WIDTH-1:0]           issue_func;
    logic [TAG_WIDTH-1:0]            issue_src1_tag;
    logic [TAG_WIDTH-1:0]            issue_src2_tag;
    logic [TAG_WIDTH-1:0]            issue_dst_tag;
    logic [ENTRY_WIDTH:0]            num_free;

    modport master (
        output dispatch_valid, dispatch_func, dispatch_src1_tag, dispatch_src2_tag,
               dispatch_src1_ready, dispatch_src2_ready, dispatch_dst_tag,
               wakeup_valid, wakeup_tag, issue_ready,
        input  dispatch_ready, issue_valid, issue_func, issue_src1_tag,
               issue_src2_tag, issue_dst_tag, num_free
    );

    modport slave (
        input  dispatch_valid, dispatch_func, dispatch_src1_tag, dispatch_src2_tag,
               dispatch_src1_ready, dispatch_src2_ready, dispatch_dst_tag,
               wakeup_valid, wakeup_tag, issue_ready,
        output dispatch_ready, issue_valid, issue_func, issue_src1_tag,
               issue_src2_tag, issue_dst_tag, num_free
    );

endinterface

// File: rtl/issue_queue_v2_age_matrix_select.sv
// Oldest-ready picker: grants entry i when it is ready and no other ready
// entry is marked older than it. older[j][i]=1 means j is older than i.
module age_matrix_select #(
    parameter int NUM_ENTRIES = 8
) (
    input  logic [NUM_ENTRIES-1:0]                  ready,
    input  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older,
    output logic [NUM_ENTRIES-1:0]                  grant,
    output logic                                    any_grant
);

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_col
            logic [NUM_ENTRIES-1:0] older_col;
            for (genvar gj = 0; gj < NUM_ENTRIES; gj++) begin : g_row
                assign older_col[gj] = older[gj][gi];
            end
            assign grant[gi] = ready[gi] && !(|(older_col & ready));
        end
    endgenerate

    assign any_grant = |grant;

endmodule

// File: rtl/issue_queue_v2.sv
// Tag-based reservation station: dispatch into the lowest free slot, wake
// sources from broadcast ports, issue the oldest ready entry through one register.
module issue_queue_v2
    import issue_queue_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int ENTRY_WIDTH = $clog2(NUM_ENTRIES),
    parameter int TAG_WIDTH   = IQ_TAG_WIDTH,
    parameter int FUNC_WIDTH  = IQ_FUNC_WIDTH,
    parameter int NUM_WAKEUP  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    issue_queue_v2_if.slave  iq
);

    localparam logic [ENTRY_WIDTH:0] FULL_COUNT = (ENTRY_WIDTH+1)'(NUM_ENTRIES);

    rs_entry_t                              entry_reg [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older_reg;
    logic [ENTRY_WIDTH:0]                   num_free_reg, num_free_next;

    logic  issue_valid_reg;
    func_t issue_func_reg;
    tag_t  issue_src1_reg, issue_src2_reg, issue_dst_reg;

    logic [NUM_ENTRIES-1:0] valid_vec, ready_vec, alloc_vec, grant_vec;
    logic [NUM_ENTRIES-1:0] wake1_vec, wake2_vec;
    logic                   any_grant, dispatch_ready, dispatch_fire, load_en;
    rs_entry_t              new_entry;
    func_t                  picked_func;
    tag_t                   picked_src1, picked_src2, picked_dst;

    function automatic logic tag_woken(
        input tag_t                            tag,
        input logic [NUM_WAKEUP-1:0]           wv,
        input logic [NUM_WAKEUP*TAG_WIDTH-1:0] wt
    );
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < NUM_WAKEUP; p++) begin
            if (wv[p] && (tag_t'(wt[p*TAG_WIDTH +: TAG_WIDTH]) == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            assign valid_vec[gi] = entry_reg[gi].valid;
            assign ready_vec[gi] = entry_reg[gi].valid && entry_reg[gi].rdy1 && entry_reg[gi].rdy2;
            assign wake1_vec[gi] = tag_woken(entry_reg[gi].src1_tag, iq.wakeup_valid, iq.wakeup_tag);
            assign wake2_vec[gi] = tag_woken(entry_reg[gi].src2_tag, iq.wakeup_valid, iq.wakeup_tag);
        end
    endgenerate

    age_matrix_select #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_select (
        .ready     (ready_vec),
        .older     (older_reg),
        .grant     (grant_vec),
        .any_grant (any_grant)
    );

    assign dispatch_ready = (num_free_reg != '0);
    assign dispatch_fire  = iq.dispatch_valid && dispatch_ready && !flush;
    assign load_en        = any_grant && (!issue_valid_reg || iq.issue_ready) && !flush;

    always_comb begin
        logic found;
        alloc_vec = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!valid_vec[i] && !found) begin
                alloc_vec[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    // Dispatch bypass: a tag broadcast in the dispatch cycle is captured as ready.
    always_comb begin
        new_entry          = EMPTY_ENTRY;
        new_entry.valid    = 1'b1;
        new_entry.func     = func_t'(iq.dispatch_func);
        new_entry.src1_tag = tag_t'(iq.dispatch_src1_tag);
        new_entry.src2_tag = tag_t'(iq.dispatch_src2_tag);
        new_entry.dst_tag  = tag_t'(iq.dispatch_dst_tag);
        new_entry.rdy1     = iq.dispatch_src1_ready || (new_entry.src1_tag == ZERO_TAG)
                             || tag_woken(new_entry.src1_tag, iq.wakeup_valid, iq.wakeup_tag);
        new_entry.rdy2     = iq.dispatch_src2_ready || (new_entry.src2_tag == ZERO_TAG)
                             || tag_woken(new_entry.src2_tag, iq.wakeup_valid, iq.wakeup_tag);
    end

    always_comb begin
        picked_func = '0;
        picked_src1 = '0;
        picked_src2 = '0;
        picked_dst  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (grant_vec[i]) begin
                picked_func = picked_func | entry_reg[i].func;
                picked_src1 = picked_src1 | entry_reg[i].src1_tag;
                picked_src2 = picked_src2 | entry_reg[i].src2_tag;
                picked_dst  = picked_dst  | entry_reg[i].dst_tag;
            end
        end
    end

    always_comb begin
        num_free_next = num_free_reg;
        if (flush) begin
            num_free_next = FULL_COUNT;
        end else begin
            if (dispatch_fire) num_free_next = num_free_next - 1'b1;
            if (load_en)       num_free_next = num_free_next + 1'b1;
        end
    end

    // Allocation and removal never target the same slot: alloc picks a free
    // slot, grant picks a valid one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) entry_reg[i] <= EMPTY_ENTRY;
        end else if (flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) entry_reg[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (dispatch_fire && alloc_vec[i]) begin
                    entry_reg[i] <= new_entry;
                end else begin
                    if (load_en && grant_vec[i])        entry_reg[i].valid <= 1'b0;
                    if (valid_vec[i] && wake1_vec[i])   entry_reg[i].rdy1  <= 1'b1;
                    if (valid_vec[i] && wake2_vec[i])   entry_reg[i].rdy2  <= 1'b1;
                end
            end
        end
    end

    // Stale rows/columns of freed slots are harmless: select only looks at
    // ready entries, and a reallocated slot rewrites both its row and column.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            older_reg <= '0;
        end else if (dispatch_fire) begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                for (int k = 0; k < NUM_ENTRIES; k++) begin
                    if (alloc_vec[k]) begin
                        older_reg[j][k] <= (j != k) && valid_vec[j];
                    end else if (alloc_vec[j]) begin
                        older_reg[j][k] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_valid_reg <= 1'b0;
            issue_func_reg  <= '0;
            issue_src1_reg  <= '0;
            issue_src2_reg  <= '0;
            issue_dst_reg   <= '0;
            num_free_reg    <= FULL_COUNT;
        end else begin
            num_free_reg <= num_free_next;
            if (flush) begin
                issue_valid_reg <= 1'b0;
                issue_func_reg  <= '0;
                issue_src1_reg  <= '0;
                issue_src2_reg  <= '0;
                issue_dst_reg   <= '0;
            end else if (load_en) begin
                issue_valid_reg <= 1'b1;
                issue_func_reg  <= picked_func;
                issue_src1_reg  <= picked_src1;
                issue_src2_reg  <= picked_src2;
                issue_dst_reg   <= picked_dst;
            end else if (iq.issue_ready) begin
                issue_valid_reg <= 1'b0;
            end
        end
    end

    assign iq.dispatch_ready = dispatch_ready;
    assign iq.issue_valid    = issue_valid_reg;
    assign iq.issue_func     = FUNC_WIDTH'(issue_func_reg);
    assign iq.issue_src1_tag = TAG_WIDTH'(issue_src1_reg);
    assign iq.issue_src2_tag = TAG_WIDTH'(issue_src2_reg);
    assign iq.issue_dst_tag  = TAG_WIDTH'(issue_dst_reg);
    assign iq.num_free       = num_free_reg;

endmodule
